// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: memory widths, function
// codes, sequencer state encodings and the default watchdog limit.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 68;

    localparam logic [1:0] FUNC_GET_CONTENTS = 2'd0;
    localparam logic [1:0] FUNC_SET_CONTENTS = 2'd1;
    localparam logic [1:0] FUNC_GET_FREE     = 2'd2;

    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick. On a tie the port that did not win last time
// is chosen; last_grant powers up as 1 so port 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        any = |req;
        if (&req)
            grant = ~last_grant;
        else
            grant = req[1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= grant;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer in front of memory_unit: grants round-robin,
// drives the execute handshake, returns the result and watches for a hung unit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int EXEC_CYCLES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0][1:0]        req_func,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_data,
    output logic [1:0]             req_ack,
    output logic [1:0]             req_done,
    output logic [ADDR_W-1:0]      resp_addr,
    output logic [DATA_W-1:0]      resp_data,
    output logic [1:0]             mem_func,
    output logic                   mem_execute,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    input  logic [ADDR_W-1:0]      mem_addr_out,
    input  logic [DATA_W-1:0]      mem_data_out,
    input  logic                   mem_is_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t        state_q, state_d;
    logic              grant_any, grant_port, take, port_q;
    logic [EXEC_W-1:0] exec_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              exec_last, wd_expired;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .take  (take),
        .any   (grant_any),
        .grant (grant_port)
    );

    assign exec_last  = (exec_cnt == EXEC_W'(EXEC_CYCLES - 1));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // NOTE: defaults are assigned first so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_is_ready && grant_any) begin
                    take    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_last)
                    state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mem_is_ready || wd_expired)
                    state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ack     <= 2'b00;
            port_q      <= 1'b0;
            mem_func    <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            resp_addr   <= '0;
            resp_data   <= '0;
            exec_cnt    <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ack <= take ? port_onehot(grant_port) : 2'b00;
            // Operands are frozen here; later req_* changes cannot disturb the op.
            if (take) begin
                port_q   <= grant_port;
                mem_func <= req_func[grant_port];
                mem_addr <= req_addr[grant_port];
                mem_data <= req_data[grant_port];
            end
            exec_cnt <= (state_q == ST_EXEC && !exec_last) ? exec_cnt + EXEC_W'(1) : '0;
            wd_cnt   <= (state_q == ST_WAIT_DONE) ? wd_cnt + WD_W'(1) : '0;
            if (state_q == ST_WAIT_DONE) begin
                if (mem_is_ready) begin
                    resp_addr <= mem_addr_out;
                    resp_data <= mem_data_out;
                end else if (wd_expired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    assign mem_execute = (state_q == ST_EXEC);
    assign busy        = (state_q != ST_IDLE);
    assign req_done    = (state_q == ST_RESP) ? port_onehot(port_q) : 2'b00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory_unit stand-in
// (6-entry preloaded image, fixed latency, optional stuck-busy mode).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW  = MEM_ADDR_W;
    localparam int DW  = MEM_DATA_W;
    localparam int TO  = 16;
    localparam int LAT = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          req_valid = '0;
    logic [1:0][1:0]     req_func  = '0;
    logic [1:0][AW-1:0]  req_addr  = '0;
    logic [1:0][DW-1:0]  req_data  = '0;
    logic [1:0]          req_ack, req_done;
    logic [AW-1:0]       resp_addr, mem_addr, stub_addr_out;
    logic [DW-1:0]       resp_data, mem_data, stub_data_out;
    logic [1:0]          mem_func;
    logic                mem_execute, busy, timeout_err, stub_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .EXEC_CYCLES(2), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_func     (req_func),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .resp_addr    (resp_addr),
        .resp_data    (resp_data),
        .mem_func     (mem_func),
        .mem_execute  (mem_execute),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_addr_out (stub_addr_out),
        .mem_data_out (stub_data_out),
        .mem_is_ready (stub_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // memory_unit stand-in
    logic [DW-1:0] mem_model [0:15];
    logic [AW-1:0] free_ptr, pend_addr;
    logic [DW-1:0] pend_data;
    logic [1:0]    pend_func;
    int            stub_cnt;
    logic          stub_stuck = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                mem_model[i] <= (i < 6) ? DW'(68'h100 + i) : '0;
            free_ptr      <= AW'(6);
            stub_ready    <= 1'b1;
            stub_cnt      <= 0;
            stub_addr_out <= '0;
            stub_data_out <= '0;
            pend_func     <= '0;
            pend_addr     <= '0;
            pend_data     <= '0;
        end else if (stub_ready && mem_execute) begin
            stub_ready <= 1'b0;
            pend_func  <= mem_func;
            pend_addr  <= mem_addr;
            pend_data  <= mem_data;
            if (!stub_stuck) stub_cnt <= LAT;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_ready <= 1'b1;
                case (pend_func)
                    FUNC_SET_CONTENTS: begin
                        mem_model[pend_addr[3:0]] <= pend_data;
                        stub_addr_out <= pend_addr;
                        stub_data_out <= pend_data;
                    end
                    FUNC_GET_CONTENTS: begin
                        stub_addr_out <= pend_addr;
                        stub_data_out <= mem_model[pend_addr[3:0]];
                    end
                    FUNC_GET_FREE: begin
                        stub_addr_out <= free_ptr;
                        stub_data_out <= '0;
                        free_ptr      <= free_ptr + AW'(1);
                    end
                    default: begin
                        stub_addr_out <= pend_addr;
                        stub_data_out <= '0;
                    end
                endcase
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    int ack_cnt [2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int ack_cyc [2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int overlap_cnt = 0;
    bit outstanding = 1'b0;
    int exec_len = 0;
    int grant_q[$];
    int exec_lens[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            outstanding = 1'b0;
            exec_len    = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (req_ack[p]) begin
                    ack_cnt[p]++;
                    ack_cyc[p] = cyc;
                    grant_q.push_back(p);
                    if (outstanding) overlap_cnt++;
                    outstanding = 1'b1;
                end
                if (req_done[p]) begin
                    done_cnt[p]++;
                    done_cyc[p] = cyc;
                    outstanding = 1'b0;
                end
            end
            if (mem_execute) exec_len++;
            else if (exec_len != 0) begin
                exec_lens.push_back(exec_len);
                exec_len = 0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [1:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_func[p]  = f;
        req_addr[p]  = a;
        req_data[p]  = d;
        req_valid[p] = 1'b1;
    endtask

    task automatic wait_ack(input int p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (req_ack[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (req_done[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_op(input int p, input logic [1:0] f, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic ok);
        logic ok_a, ok_d;
        drive(p, f, a, d);
        wait_ack(p, ok_a);
        req_valid[p] = 1'b0;
        wait_done(p, ok_d);
        step();
        ok = ok_a & ok_d;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic ok;
        int   b_ack0, b_done0, b_ack1, nexec, base, n0, n1, bad;

        // Reset state
        repeat (3) step();
        check("rst_req_ack", req_ack, 2'b00);
        check("rst_req_done", req_done, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_execute", mem_execute, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b1;
        step();

        // Port 0 write
        b_ack0  = ack_cnt[0];
        b_done0 = done_cnt[0];
        nexec   = exec_lens.size();
        do_op(0, FUNC_SET_CONTENTS, AW'(5), 68'hDEADBEEF, ok);
        check("wr_complete", ok, 1'b1);
        check("wr_ack_count", ack_cnt[0] - b_ack0, 1);
        check("wr_done_count", done_cnt[0] - b_done0, 1);
        check("wr_exec_len", (exec_lens.size() > nexec) ? exec_lens[nexec] : -1, 2);
        check("wr_latency", done_cyc[0] - ack_cyc[0], 5);
        check("wr_mem_func", mem_func, FUNC_SET_CONTENTS);
        check("wr_busy_after", busy, 1'b0);

        // Port 0 read back
        do_op(0, FUNC_GET_CONTENTS, AW'(5), '0, ok);
        check("rd_complete", ok, 1'b1);
        check("rd_resp_data", resp_data, 68'hDEADBEEF);
        check("rd_resp_addr", resp_addr, AW'(5));

        // Port 1 GET_FREE
        do_op(1, FUNC_GET_FREE, '0, '0, ok);
        check("free_complete", ok, 1'b1);
        check("free_resp_addr", resp_addr, AW'(6));
        check("free_timeout_err", timeout_err, 1'b0);

        // Both ports loaded right after reset: strict alternation
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        base  = grant_q.size();
        nexec = exec_lens.size();
        b_ack0 = overlap_cnt;
        drive(0, FUNC_GET_CONTENTS, AW'(0), '0);
        drive(1, FUNC_GET_CONTENTS, AW'(1), '0);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (req_ack[0]) begin
                n0++;
                if (n0 == 4) req_valid[0] = 1'b0;
            end
            if (req_ack[1]) begin
                n1++;
                if (n1 == 4) req_valid[1] = 1'b0;
            end
            if (n0 == 4 && n1 == 4 && !busy) break;
        end
        req_valid = 2'b00;
        step();
        check("rr_acks_port0", n0, 4);
        check("rr_acks_port1", n1, 4);
        for (int i = 0; i < 8; i++)
            check($sformatf("rr_order_%0d", i),
                  (base + i < grant_q.size()) ? grant_q[base + i] : -1, i % 2);
        check("rr_no_overlap", overlap_cnt - b_ack0, 0);
        bad = 0;
        for (int i = nexec; i < exec_lens.size(); i++)
            if (exec_lens[i] != 2) bad++;
        check("rr_exec_windows", exec_lens.size() - nexec, 8);
        check("rr_exec_lengths", bad, 0);

        // Port 1 arrives while port 0 is in WAIT_DONE
        drive(0, FUNC_GET_CONTENTS, AW'(1), '0);
        wait_ack(0, ok);
        check("busy_ack0", ok, 1'b1);
        req_valid[0] = 1'b0;
        repeat (3) step();
        b_ack1 = ack_cnt[1];
        drive(1, FUNC_SET_CONTENTS, AW'(7), 68'h1_2345_6789);
        wait_done(0, ok);
        check("busy_done0", ok, 1'b1);
        wait_ack(1, ok);
        check("busy_ack1", ok, 1'b1);
        req_valid[1] = 1'b0;
        wait_done(1, ok);
        check("busy_done1", ok, 1'b1);
        step();
        check("busy_ack1_count", ack_cnt[1] - b_ack1, 1);
        check("busy_ack1_gap", ack_cyc[1] - done_cyc[0], 2);
        check("busy_resp_data", resp_data, 68'h1_2345_6789);

        // Hung memory unit: watchdog
        stub_stuck = 1'b1;
        do_op(0, FUNC_GET_CONTENTS, AW'(5), '0, ok);
        check("to_complete", ok, 1'b1);
        check("to_done_delay", done_cyc[0] - ack_cyc[0], 18);
        check("to_flag", timeout_err, 1'b1);
        check("to_resp_data_kept", resp_data, 68'h1_2345_6789);
        check("to_resp_addr_kept", resp_addr, AW'(7));
        b_ack1 = ack_cnt[1];
        drive(1, FUNC_GET_CONTENTS, AW'(2), '0);
        repeat (6) step();
        req_valid[1] = 1'b0;
        step();
        check("to_no_grant_not_ready", ack_cnt[1] - b_ack1, 0);
        check("to_flag_sticky", timeout_err, 1'b1);
        check("to_idle", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("to_flag_cleared_by_rst", timeout_err, 1'b0);
        repeat (2) step();
        stub_stuck = 1'b0;
        rst = 1'b1;
        step();

        // Reset during EXEC
        drive(1, FUNC_GET_CONTENTS, AW'(2), '0);
        wait_ack(1, ok);
        check("rx_ack", ok, 1'b1);
        check("rx_exec_high", mem_execute, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rx_exec_low", mem_execute, 1'b0);
        check("rx_busy_low", busy, 1'b0);
        check("rx_ack_low", req_ack, 2'b00);
        check("rx_done_low", req_done, 2'b00);
        repeat (2) step();
        rst = 1'b1;
        drive(0, FUNC_GET_CONTENTS, AW'(3), '0);
        drive(1, FUNC_GET_CONTENTS, AW'(4), '0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req_ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check("rx_first_tie_seen", ok, 1'b1);
        check("rx_first_tie_port0", req_ack, 2'b01);
        req_valid = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) break;
        end
        check("rx_final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of `memory_unit`. It accepts memory operations (`GET_CONTENTS`, `SET_CONTENTS`, `GET_FREE`) from two requesters: port 0, the NockPU execute/traversal engine, and port 1, the loader/debug port. It grants them round-robin and drives the `memory_unit` execute handshake. It returns `addr_out`/`data_out` to the winning requester with a one-cycle done pulse, and flags a hung memory unit with a timeout error.

## Interface
- `ADDR_W`, default `` `memory_addr_width `` (from `memory_unit.vh`): address width.
- `DATA_W`, default `` `memory_data_width ``: data word width.
- `EXEC_CYCLES`, default 2: cycles `mem_execute` is held high per operation.
- `TIMEOUT`, default 1024: maximum cycles spent in WAIT_DONE before the error flag is raised.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  2  per-port request; held until `req_ack` is seen.
- `req_func`  in  2×2  per-port memory function code (`` `GET_CONTENTS ``/`` `SET_CONTENTS ``/`` `GET_FREE ``).
- `req_addr`  in  2×ADDR_W  per-port address.
- `req_data`  in  2×DATA_W  per-port write data.
- `req_ack`  out  2  one-cycle pulse when a port's request is captured.
- `req_done`  out  2  one-cycle pulse when that port's operation completes.
- `resp_addr`  out  ADDR_W  registered `mem_addr_out` of the last completed operation.
- `resp_data`  out  DATA_W  registered `mem_data_out` of the last completed operation.
- `mem_func`  out  2  to `memory_unit.func`.
- `mem_execute`  out  1  to `memory_unit.execute`.
- `mem_addr`  out  ADDR_W  to `memory_unit.addr_in`.
- `mem_data`  out  DATA_W  to `memory_unit.data_in`.
- `mem_addr_out`  in  ADDR_W  from `memory_unit.addr_out`.
- `mem_data_out`  in  DATA_W  from `memory_unit.data_out`.
- `mem_is_ready`  in  1  from `memory_unit.is_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
- States: IDLE, EXEC, WAIT_DONE, RESP.
- IDLE:
  - Arbitration happens only when `mem_is_ready` is 1 and at least one `req_valid` is high.
  - Round-robin: the port not granted last wins a tie. After reset, `last_grant` is 1, so port 0 wins the first tie.
  - On a grant: capture func, addr and data into the `mem_*` registers; pulse `req_ack[g]`; set `last_grant` to g; go to EXEC.
- EXEC: `mem_execute` is 1 for exactly `EXEC_CYCLES` cycles (counter), then goes 0; go to WAIT_DONE.
- WAIT_DONE:
  - When `mem_is_ready` is sampled 1: latch `mem_addr_out`/`mem_data_out` into `resp_*` and go to RESP.
  - A watchdog counts cycles in this state. When it reaches `TIMEOUT`: set `timeout_err`, leave `resp_*` unchanged, still pulse `req_done`, and go to RESP. This prevents a deadlock.
- RESP: pulse `req_done[g]`; go to IDLE. `resp_*` holds its value until the next completion.
- Only one operation is outstanding at a time. A request that arrives while the block is busy waits; it is not dropped.
- `mem_func`/`mem_addr`/`mem_data` stay stable from EXEC through RESP.
- A `req_valid` deasserted before its ack is simply not served. After an ack, changes on the `req_*` inputs do not affect the operation in flight.
- Unknown func encodings are passed through unchanged.
- Reset mid-operation: all state returns to IDLE immediately. The memory unit is reset by the same `rst`.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `last_grant` 1, counters 0.
- Grant latency: `req_ack` rises the cycle after `req_valid` is sampled in IDLE with `mem_is_ready` 1. `mem_execute` rises on that same edge.
- Total latency from ack to done: `EXEC_CYCLES` + (cycles until `mem_is_ready`) + 1.
- Minimum gap between two operations: one IDLE cycle after RESP.
- Both ports fairly loaded: grants strictly alternate.

## Structure
- Add state encodings and the default `TIMEOUT` to `memory_unit.vh`, next to the func codes.
- Natural sub-module: `rr_arbiter2`, a combinational two-request round-robin pick plus the registered `last_grant`.
- The top level instantiates `rr_arbiter2` and the FSM. `memory_unit` is instantiated by the parent, not inside this block.

## Test plan
- Single write then read, with a `memory_unit` instance preloaded from `memory.hex`:
  - Port 0 `SET_CONTENTS` addr 5, data 68'hDEADBEEF → one `req_ack[0]`, `mem_execute` high for 2 cycles, then one `req_done[0]`.
  - Port 0 `GET_CONTENTS` addr 5 → `resp_data` = 68'hDEADBEEF.
- `GET_FREE` on port 1 → `req_done[1]` pulses; `resp_addr` equals the memory unit's free pointer (6 for the 6-entry image).
- Simultaneous requests on both ports, 4 each, immediately after reset → grant order 0,1,0,1,0,1,0,1, and no overlap of `mem_execute` windows.
- Port 1 asserts a request while port 0's operation is in WAIT_DONE → port 1 is acked only after `req_done[0]` plus one IDLE cycle.
- Stub `mem_is_ready` stuck at 0 after execute, with `TIMEOUT` = 16 → `req_done` pulses 16 cycles after entering WAIT_DONE; `timeout_err` = 1 and stays 1 until `rst`.
- `rst` asserted low during EXEC → `mem_execute`, `busy`, `req_ack` and `req_done` drop to 0 asynchronously. After release, the first tie goes to port 0.
